reaction_match_ctrl: RTL and testbench

//  Match controller for the two-player reaction game. Sequences ROUNDS rounds of the LED countdown
//  / random-delay datapath: arms the light sequencer, waits for the go stimulus, arbitrates the first

---
 rtl/reaction_match_ctrl.sv | 179 +++++++++++++++++
 tb/tb_reaction_match_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_match_ctrl.sv
// Two-player reaction match sequencer: arms the light sequencer, arbitrates the first press, scores rounds.
// All outputs registered; trigger follows an accepted start by 1 clk; start is ignored while busy.
module reaction_match_ctrl #(
  parameter int ROUNDS     = 5,
  parameter int TIME_W     = 12,
  parameter int TIMEOUT_MS = 1000,
  parameter int HOLD_MS    = 2000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick_ms,
  input  logic              start,
  input  logic              lights_done,
  input  logic              react_a,
  input  logic              react_b,
  output logic              trigger,
  output logic              busy,
  output logic [1:0]        winner,
  output logic              false_start,
  output logic [TIME_W-1:0] react_time,
  output logic [3:0]        score_a,
  output logic [3:0]        score_b,
  output logic [3:0]        round_num,
  output logic              match_done
);

  localparam int                HOLD_W    = $clog2(HOLD_MS + 1);
  localparam logic [TIME_W-1:0] TIMEOUT_V = TIME_W'(TIMEOUT_MS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MS - 1);
  localparam logic [3:0]        ROUNDS_V  = 4'(ROUNDS);

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_GO,
    TIMING,
    RESULT,
    DONE
  } state_t;

  state_t            state;
  logic              a_q;
  logic              b_q;
  logic [HOLD_W-1:0] hold_cnt;

  logic              press_a;
  logic              press_b;
  logic              any_press;
  logic [TIME_W-1:0] rt_next;

  // A press is a rising edge only, so a button held down never re-arms itself.
  assign press_a   = react_a & ~a_q;
  assign press_b   = react_b & ~b_q;
  assign any_press = press_a | press_b;
  assign rt_next   = react_time + TIME_W'(1);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      hold_cnt    <= '0;
      trigger     <= 1'b0;
      busy        <= 1'b0;
      winner      <= WIN_NONE;
      false_start <= 1'b0;
      react_time  <= '0;
      score_a     <= '0;
      score_b     <= '0;
      round_num   <= '0;
      match_done  <= 1'b0;
    end else begin
      a_q     <= react_a;
      b_q     <= react_b;
      trigger <= 1'b0;
      if (state != RESULT) begin
        hold_cnt <= '0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= ARM;
            trigger     <= 1'b1;
            busy        <= 1'b1;
            match_done  <= 1'b0;
            round_num   <= 4'd1;
            score_a     <= '0;
            score_b     <= '0;
            winner      <= WIN_NONE;
            false_start <= 1'b0;
            react_time  <= '0;
          end
        end

        ARM: begin
          state <= WAIT_GO;
        end

        // A press seen on or before the go edge is a foul; the opponent takes the point.
        WAIT_GO: begin
          if (any_press) begin
            state       <= RESULT;
            false_start <= 1'b1;
            case ({press_b, press_a})
              2'b01: begin
                winner  <= WIN_B;
                score_b <= sat_inc(score_b);
              end
              2'b10: begin
                winner  <= WIN_A;
                score_a <= sat_inc(score_a);
              end
              default: winner <= WIN_NONE;
            endcase
          end else if (lights_done) begin
            state <= TIMING;
          end
        end

        TIMING: begin
          if (any_press) begin
            state <= RESULT;
            case ({press_b, press_a})
              2'b01: begin
                winner  <= WIN_A;
                score_a <= sat_inc(score_a);
              end
              2'b10: begin
                winner  <= WIN_B;
                score_b <= sat_inc(score_b);
              end
              default: winner <= WIN_TIE;
            endcase
          end else if (tick_ms) begin
            react_time <= rt_next;
            if (rt_next == TIMEOUT_V) begin
              state  <= RESULT;
              winner <= WIN_NONE;
            end
          end
        end

        RESULT: begin
          if (tick_ms) begin
            if (hold_cnt == HOLD_LAST) begin
              false_start <= 1'b0;
              if (round_num == ROUNDS_V) begin
                state      <= DONE;
                busy       <= 1'b0;
                match_done <= 1'b1;
              end else begin
                state      <= ARM;
                trigger    <= 1'b1;
                round_num  <= round_num + 4'd1;
                winner     <= WIN_NONE;
                react_time <= '0;
              end
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_match_ctrl.sv
// Bench for reaction_match_ctrl: round plans drive the pins, a round-level model predicts each result.
// tick_ms strobes on every even-numbered clock edge, so ms counts follow from edge indices.
module tb_reaction_match_ctrl;

  localparam int ROUNDS     = 5;
  localparam int TIME_W     = 12;
  localparam int TIMEOUT_MS = 1000;
  localparam int HOLD_MS    = 2000;
  localparam int NONE       = -1;
  localparam int AFTER_REF  = -2;
  localparam int REF_TICKS  = 237;
  localparam int FAR        = 1 << 30;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              tick_ms;
  logic              start;
  logic              lights_done;
  logic              react_a;
  logic              react_b;
  logic              trigger;
  logic              busy;
  logic [1:0]        winner;
  logic              false_start;
  logic [TIME_W-1:0] react_time;
  logic [3:0]        score_a;
  logic [3:0]        score_b;
  logic [3:0]        round_num;
  logic              match_done;

  int total = 0;
  int bad = 0;
  int n = 0;
  int trig_cnt = 0;
  int sa = 0;
  int sb = 0;
  int last_win = 0;
  int last_rt = 0;

  int go_d[ROUNDS];
  int a_d[ROUNDS];
  int b_d[ROUNDS];
  int a_drop[ROUNDS];
  bit a_pre[ROUNDS];

  always #5 clk = ~clk;

  reaction_match_ctrl #(
    .ROUNDS(ROUNDS), .TIME_W(TIME_W), .TIMEOUT_MS(TIMEOUT_MS), .HOLD_MS(HOLD_MS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick_ms(tick_ms), .start(start),
    .lights_done(lights_done), .react_a(react_a), .react_b(react_b),
    .trigger(trigger), .busy(busy), .winner(winner), .false_start(false_start),
    .react_time(react_time), .score_a(score_a), .score_b(score_b),
    .round_num(round_num), .match_done(match_done)
  );

  always @(negedge clk) if (trigger === 1'b1) trig_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time expired (bad=%0d)", bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
    end
  endtask

  function automatic bit tick_at(input int p);
    return (p % 2) == 0;
  endfunction

  function automatic int press_after(input int go, input int k);
    int p;
    int c;
    p = go + 1;
    c = 0;
    while (c < k) begin
      if (tick_at(p)) c++;
      p++;
    end
    return p;
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  function automatic logic rand_start();
    return ($urandom_range(0, 63) == 0);
  endfunction

  // Drive inputs for edge n, let it happen, return at the following negedge.
  task automatic step(input logic a, input logic b, input logic ld, input logic st);
    react_a     = a;
    react_b     = b;
    lights_done = ld;
    start       = st;
    tick_ms     = tick_at(n);
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_trigger"}, int'(trigger), 0);
    chk({pfx, "_busy"}, int'(busy), 0);
    chk({pfx, "_winner"}, int'(winner), 0);
    chk({pfx, "_false_start"}, int'(false_start), 0);
    chk({pfx, "_react_time"}, int'(react_time), 0);
    chk({pfx, "_score_a"}, int'(score_a), 0);
    chk({pfx, "_score_b"}, int'(score_b), 0);
    chk({pfx, "_round_num"}, int'(round_num), 0);
    chk({pfx, "_match_done"}, int'(match_done), 0);
  endtask

  task automatic start_match(input bit hold_a);
    step(hold_a, 1'b0, 1'b0, 1'b1);
    sa = 0;
    sb = 0;
    chk("start_trigger", int'(trigger), 1);
    chk("start_busy", int'(busy), 1);
    chk("start_round", int'(round_num), 1);
    chk("start_scores", int'({score_a, score_b}), 0);
    chk("start_done", int'(match_done), 0);
  endtask

  // Entered at the negedge of the ARM cycle; returns at the negedge after the hold ends.
  task automatic run_round(input int i, input bit next_pre);
    int w, go, ad, ea, eb, fp, r, h, cnt, j;
    int exp_win, exp_fs, exp_rt;
    logic a_lv, b_lv;
    w  = n + 1;
    go = w + go_d[i];
    ad = a_d[i];
    if (ad == AFTER_REF) ad = press_after(go, REF_TICKS) - w;
    ea = (ad < 0) ? FAR : w + ad;
    eb = (b_d[i] < 0) ? FAR : w + b_d[i];
    fp = (ea < eb) ? ea : eb;
    exp_win = 0;
    exp_fs  = 0;
    exp_rt  = 0;
    r       = -1;
    if (fp <= go) begin
      exp_fs = 1;
      r      = fp;
      if (ea == fp && eb == fp) exp_win = 0;
      else if (ea == fp) begin exp_win = 2; sb = sat15(sb + 1); end
      else begin exp_win = 1; sa = sat15(sa + 1); end
    end else begin
      cnt = 0;
      for (int p = go + 1; r < 0; p++) begin
        if (p == fp) begin
          r      = p;
          exp_rt = cnt;
          if (ea == fp && eb == fp) exp_win = 3;
          else if (ea == fp) begin exp_win = 1; sa = sat15(sa + 1); end
          else begin exp_win = 2; sb = sat15(sb + 1); end
        end else if (tick_at(p)) begin
          cnt++;
          if (cnt == TIMEOUT_MS) begin
            r      = p;
            exp_rt = cnt;
            exp_win = 0;
          end
        end
      end
    end

    for (int p = n; p <= r; p++) begin
      j = p - w;
      if (p == r) begin
        chk("pre_result_winner", int'(winner), 0);
        chk("pre_result_false_start", int'(false_start), 0);
      end
      a_lv = (a_pre[i] && j < a_drop[i]) || (ad >= 0 && j >= ad);
      b_lv = (b_d[i] >= 0 && j >= b_d[i]);
      step(a_lv, b_lv, j >= go_d[i], rand_start());
    end
    chk("result_winner", int'(winner), exp_win);
    chk("result_false_start", int'(false_start), exp_fs);
    chk("result_react_time", int'(react_time), exp_rt);
    chk("result_score_a", int'(score_a), sa);
    chk("result_score_b", int'(score_b), sb);
    chk("result_round", int'(round_num), i + 1);
    chk("result_busy", int'(busy), 1);
    chk("result_trigger", int'(trigger), 0);

    cnt = 0;
    h   = -1;
    for (int p = r + 1; h < 0; p++) begin
      if (tick_at(p)) begin
        cnt++;
        if (cnt == HOLD_MS) h = p;
      end
    end
    for (int p = r + 1; p <= h; p++) begin
      if (p == h) begin
        chk("hold_winner", int'(winner), exp_win);
        chk("hold_trigger", int'(trigger), 0);
        chk("hold_round", int'(round_num), i + 1);
      end
      if (h - p < 20) step(next_pre, 1'b0, 1'b0, rand_start());
      else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rand_start());
    end
    last_win = exp_win;
    last_rt  = exp_rt;
    if (i == ROUNDS - 1) begin
      chk("done_match_done", int'(match_done), 1);
      chk("done_busy", int'(busy), 0);
      chk("done_trigger", int'(trigger), 0);
      chk("done_false_start", int'(false_start), 0);
    end else begin
      chk("next_trigger", int'(trigger), 1);
      chk("next_round", int'(round_num), i + 2);
      chk("next_winner", int'(winner), 0);
      chk("next_react_time", int'(react_time), 0);
      chk("next_false_start", int'(false_start), 0);
    end
  endtask

  task automatic play_match();
    int t0;
    t0 = trig_cnt;
    start_match(a_pre[0]);
    for (int i = 0; i < ROUNDS; i++) run_round(i, (i < ROUNDS - 1) ? a_pre[i + 1] : 1'b0);
    chk("match_trigger_count", trig_cnt - t0, ROUNDS);
    repeat (40) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'b0);
    chk("frozen_match_done", int'(match_done), 1);
    chk("frozen_winner", int'(winner), last_win);
    chk("frozen_react_time", int'(react_time), last_rt);
    chk("frozen_score_a", int'(score_a), sa);
    chk("frozen_score_b", int'(score_b), sb);
    chk("frozen_trigger_count", trig_cnt - t0, ROUNDS);
  endtask

  task automatic set_round(input int i, input int g, input int a, input int b, input bit pre,
                           input int drop);
    go_d[i] = g; a_d[i] = a; b_d[i] = b; a_pre[i] = pre; a_drop[i] = drop;
  endtask

  task automatic rand_round(input int i);
    int g, a, b, drop;
    bit pre;
    g    = $urandom_range(1, 150);
    pre  = ($urandom_range(0, 3) == 0);
    drop = $urandom_range(0, 200);
    a    = ($urandom_range(0, 3) == 0) ? NONE : $urandom_range(0, g + 400);
    if (pre && a != NONE) a = drop + 1 + $urandom_range(0, 300);
    case ($urandom_range(0, 3))
      0:       b = NONE;
      1:       b = a;
      default: b = $urandom_range(0, g + 400);
    endcase
    set_round(i, g, a, b, pre, drop);
  endtask

  initial begin
    reset_n = 1'b0;
    tick_ms = 1'b0; start = 1'b0; lights_done = 1'b0; react_a = 1'b0; react_b = 1'b0;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_zero("reset");
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Abort a round mid-TIMING with reset.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_trigger", int'(trigger), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (31) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("abort_busy", int'(busy), 1);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk_zero("midreset");
    reset_n = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_winner", int'(winner), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Match 1: reference press, foul by B, tie in TIMING, tie in WAIT_GO, timeout.
    set_round(0, 100, AFTER_REF, NONE, 1'b0, 0);
    set_round(1, 100, NONE, 40, 1'b0, 0);
    set_round(2, 30, 200, 200, 1'b0, 0);
    set_round(3, 80, 20, 20, 1'b0, 0);
    set_round(4, 10, NONE, NONE, 1'b0, 0);
    play_match();

    // Match 2: A held across ARM, press on the go edge, then random rounds.
    set_round(0, 50, 400, NONE, 1'b1, 300);
    set_round(1, 60, 60, NONE, 1'b0, 0);
    for (int i = 2; i < ROUNDS; i++) rand_round(i);
    play_match();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
